// File: rtl/cmp_sort_ctrl.sv
// Batch sorter: loads N signed words, bubble-sorts them in place with one
// sign-first compare/swap per cycle (early exit on a swap-free pass), then
// streams them out in ascending order. Valid/ready handshakes on both sides.
module cmp_sort_ctrl #(
   parameter int N = 4,
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic         busy,
   output logic         done,
   output logic [5:0]   swap_count
);

   localparam int IW = $clog2(N);
   localparam logic [IW-1:0] LAST      = IW'(N - 1);
   localparam logic [IW-1:0] LAST_PASS = IW'(N - 2);

   typedef enum logic [1:0] {
      S_LOAD,
      S_SORT,
      S_OUT
   } state_t;

   state_t        state, state_next;
   logic [W-1:0]  mem [N];
   logic [IW-1:0] load_idx, out_idx, pass, j, j1;
   logic          pass_swap;
   logic [W-1:0]  a, b;
   logic          gt, last_cmp, sort_end, load_acc, out_acc;

   // Sign-first greater-than: a non-negative word beats a negative one,
   // otherwise the raw bit patterns are compared unsigned.
   function automatic logic sgt(input logic [W-1:0] x, input logic [W-1:0] y);
      if (x[W-1] != y[W-1])
         return !x[W-1];
      else
         return x > y;
   endfunction

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_LOAD;
      else
         state <= state_next;
   end

   // Next-state logic, compare slot and state-decoded outputs
   always_comb begin
      state_next = state;
      j1         = j + IW'(1);
      a          = mem[j];
      b          = mem[j1];
      gt         = sgt(a, b);
      load_acc   = in_valid && (state == S_LOAD);
      out_acc    = out_ready && (state == S_OUT);
      last_cmp   = (j == LAST_PASS - pass);
      sort_end   = last_cmp && (!(pass_swap || gt) || (pass == LAST_PASS));
      in_ready   = (state == S_LOAD);
      out_valid  = (state == S_OUT);
      busy       = (state == S_SORT);
      out_data   = mem[out_idx];
      case (state)
         S_LOAD: if (load_acc && (load_idx == LAST)) state_next = S_SORT;
         S_SORT: if (sort_end) state_next = S_OUT;
         S_OUT:  if (out_acc && (out_idx == LAST)) state_next = S_LOAD;
         default: state_next = S_LOAD;
      endcase
      if (clr)
         state_next = S_LOAD;
   end

   // Buffer, indices, pass bookkeeping, swap counter and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < N; i++)
            mem[i] <= '0;
         load_idx   <= '0;
         out_idx    <= '0;
         pass       <= '0;
         j          <= '0;
         pass_swap  <= 1'b0;
         swap_count <= '0;
         done       <= 1'b0;
      end else if (clr) begin
         load_idx   <= '0;
         out_idx    <= '0;
         pass       <= '0;
         j          <= '0;
         pass_swap  <= 1'b0;
         swap_count <= '0;
         done       <= 1'b0;
      end else begin
         done <= (state == S_SORT) && (state_next == S_OUT);
         case (state)
            S_LOAD: begin
               if (load_acc) begin
                  mem[load_idx] <= in_data;
                  load_idx      <= (load_idx == LAST) ? '0 : load_idx + IW'(1);
                  if (load_idx == '0)
                     swap_count <= '0;
               end
            end
            S_SORT: begin
               if (gt) begin
                  mem[j]     <= b;
                  mem[j1]    <= a;
                  swap_count <= swap_count + 6'd1;
               end
               if (sort_end) begin
                  j         <= '0;
                  pass      <= '0;
                  pass_swap <= 1'b0;
               end else if (last_cmp) begin
                  j         <= '0;
                  pass      <= pass + IW'(1);
                  pass_swap <= 1'b0;
               end else begin
                  j         <= j1;
                  pass_swap <= pass_swap | gt;
               end
            end
            S_OUT: begin
               if (out_acc)
                  out_idx <= (out_idx == LAST) ? '0 : out_idx + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Randomized bench for cmp_sort_ctrl against a sorting/inversion-count model.
module tb_cmp_sort_ctrl;

   localparam int N = 4;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n, clr, in_valid, out_ready;
   logic [W-1:0] in_data;
   logic         in_ready, out_valid, busy, done;
   logic [W-1:0] out_data;
   logic [5:0]   swap_count;

   int checks = 0;
   int errors = 0;

   cmp_sort_ctrl #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .swap_count (swap_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: sorted order, swaps = inversion count, sort cycles from the
   // number of bubble passes (max count of larger words to a word's left,
   // plus one clean pass, capped at N-1 passes).
   function automatic void model(input int w[N], output int s[N],
                                 output int swaps, output int cycles);
      int maxl, passes, t;
      s = w;
      for (int i = 1; i < N; i++)
         for (int k = i; k > 0 && s[k-1] > s[k]; k--) begin
            t = s[k]; s[k] = s[k-1]; s[k-1] = t;
         end
      swaps = 0;
      maxl  = 0;
      for (int k = 0; k < N; k++) begin
         int left = 0;
         for (int i = 0; i < k; i++)
            if (w[i] > w[k]) left++;
         swaps += left;
         if (left > maxl) maxl = left;
      end
      passes = (maxl + 1 < N - 1) ? maxl + 1 : N - 1;
      cycles = 0;
      for (int p = 0; p < passes; p++)
         cycles += N - 1 - p;
   endfunction

   // abort: 0 = full batch, 1 = rst_n in 3rd SORT cycle, 2 = clr in OUT
   task automatic run_batch(input int w[N], input int first_stall, input int abort);
      int s[N];
      int sw, cyc, n, done_seen, stall;
      model(w, s, sw, cyc);
      for (int i = 0; i < N; i++) begin
         if (i == 0) check("in_ready_load", int'(in_ready), 1);
         in_valid = 1'b1;
         in_data  = W'(w[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      n = 0;
      while (busy && n < 200) begin
         n++;
         if (abort == 1 && n == 3) begin
            in_valid = 1'b0;
            rst_n    = 1'b0;
            #1;
            check("rst_in_ready", int'(in_ready), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_out_valid", int'(out_valid), 0);
            check("rst_swap_count", int'(swap_count), 0);
            @(negedge clk);
            rst_n = 1'b1;
            return;
         end
         in_valid = 1'($urandom_range(0, 1));
         in_data  = W'($urandom);
         @(negedge clk);
      end
      check("sort_cycles", n, cyc);
      check("done_entry", int'(done), 1);
      check("swap_count", int'(swap_count), sw);
      if (abort == 2) begin
         clr = 1'b1;
         @(negedge clk);
         clr      = 1'b0;
         in_valid = 1'b0;
         check("clr_in_ready", int'(in_ready), 1);
         check("clr_out_valid", int'(out_valid), 0);
         check("clr_swap_count", int'(swap_count), 0);
         return;
      end
      done_seen = 0;
      for (int k = 0; k < N; k++) begin
         stall = (k == 0) ? first_stall : $urandom_range(0, 2);
         for (int c = 0; c <= stall; c++) begin
            out_ready = (c == stall);
            check("out_valid", int'(out_valid), 1);
            check("out_data", int'($signed(out_data)), s[k]);
            check("swap_hold", int'(swap_count), sw);
            done_seen += int'(done);
            in_valid = 1'($urandom_range(0, 1));
            in_data  = W'($urandom);
            @(negedge clk);
         end
      end
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("done_pulses", done_seen, 1);
      check("back_in_ready", int'(in_ready), 1);
      check("back_out_valid", int'(out_valid), 0);
   endtask

   initial begin
      int t[N];
      rst_n     = 1'b0;
      clr       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_in_ready", int'(in_ready), 1);
      check("reset_out_valid", int'(out_valid), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_swap_count", int'(swap_count), 0);
      rst_n = 1'b1;
      @(negedge clk);

      t = '{3, -2, 7, -8};   run_batch(t, 5, 0);
      t = '{-8, -1, 0, 7};   run_batch(t, 0, 0);
      t = '{7, 3, 0, -8};    run_batch(t, 1, 0);
      t = '{5, 5, -3, -3};   run_batch(t, 0, 0);
      t = '{7, 3, 0, -8};    run_batch(t, 0, 1);
      t = '{1, 0, -1, 2};    run_batch(t, 0, 0);
      t = '{3, -2, 7, -8};   run_batch(t, 0, 2);
      t = '{-8, 7, -8, 7};   run_batch(t, 0, 0);

      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < N; i++)
            if (r % 3 == 0)
               t[i] = int'($urandom_range(0, 3)) - 2;
            else
               t[i] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
         run_batch(t, int'($urandom_range(0, 3)), 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
Sequencing controller that buffers N signed W-bit words and sorts them ascending with a single time-shared signed compare/swap slot, one compare per cycle (bubble sort with early exit). The compare uses sign-first semantics, matching the team's signed 4-bit comparator. Sits between a sample producer and a consumer. Both sides use valid/ready handshakes.

Parameters:
N, 4, number of words per batch (legal 2..8)
W, 4, word width, two's complement (legal 2..8)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort: discard batch, return to LOAD
in_valid  input  1  in_data valid
in_data  input  W  signed input word
in_ready  output  1  high in LOAD only
out_valid  output  1  high in OUT only
out_data  output  W  current sorted word, ascending order
out_ready  input  1  consumer accepts out_data
busy  output  1  high in SORT
done  output  1  one-cycle pulse on the first cycle of OUT
swap_count  output  6  swaps performed in current/last batch

Behaviour:
- Reset (async, rst_n=0):
  - State goes to LOAD.
  - in_ready=1. out_valid=0, busy=0, done=0, swap_count=0.
  - Buffer, load index, pass counter and j counter all clear to 0.
- States: LOAD -> SORT -> OUT -> LOAD.
- LOAD:
  - An accept occurs on in_valid&in_ready. The word is written to mem[load_idx], then load_idx increments.
  - The accept of word N-1 moves the FSM to SORT next cycle.
  - swap_count clears on the first accept of a batch.
- SORT:
  - in_ready=0. Input is ignored while in_ready=0.
  - Each cycle compares mem[j] and mem[j+1].
  - Greater-than rule: if the sign bits differ, the word with MSB=0 is greater. Otherwise compare the raw bits unsigned.
  - If mem[j] > mem[j+1], swap both words in the same cycle and increment swap_count.
  - Equal words are never swapped.
  - j steps 0..N-2-p. At the end of pass p, a pass with zero swaps, or p=N-2, ends the sort. Otherwise p increments and j resets to 0.
  - SORT cycles: best case N-1, worst case N(N-1)/2 (6 for N=4).
- OUT:
  - done pulses on entry.
  - out_data=mem[out_idx], starting at out_idx=0.
  - out_idx advances on out_valid&out_ready.
  - out_data and out_valid are held stable while out_ready=0.
  - The accept of word N-1 moves the FSM to LOAD next cycle.
  - swap_count holds until the next batch starts.
- clr:
  - Takes effect at the next edge from any state and has priority over all other events.
  - Moves the FSM to LOAD and clears the indices and swap_count.
  - Buffer contents become don't-care.
- Reset asserted mid-SORT or mid-OUT behaves identically to power-on reset. No partial output is produced afterwards.
- Outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

Test Plan:
- N=4: load 3,-2,7,-8 -> out -8,-2,3,7; swap_count=4; SORT lasts 6 cycles; done pulses once.
- Load -8,-1,0,7 (already sorted) -> out unchanged; swap_count=0; SORT lasts 3 cycles (early exit after pass 0).
- Load 7,3,0,-8 (reversed) -> out -8,0,3,7; swap_count=6; sign-first check: 7 (0111) must follow -8 (1000).
- Load 5,5,-3,-3 -> out -3,-3,5,5; swap_count=4; equal pairs are never swapped.
- Hold out_ready=0 for 5 cycles after done -> out_data stays -8 and out_valid stays 1; in_valid pulses during SORT/OUT are not accepted.
- Assert rst_n=0 in the 3rd SORT cycle, then load 1,0,-1,2 -> out -1,0,1,2; clr during OUT -> in_ready=1 next cycle, swap_count=0.
